// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR channel arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   MODE_*      : values for the RR_MODE parameter
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam bit MODE_FIXED = 1'b0;  // lowest eligible channel wins
    localparam bit MODE_RR    = 1'b1;  // round-robin starting after last grant

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for the DDR channel arbiter.
// Ports:
//   eligible   in  NUM_CH  channels allowed to win this cycle
//   last_grant in  ID_W    previous winner (round-robin mode only)
//   grant      out NUM_CH  one-hot winner, all-zero when nothing is eligible
//   grant_idx  out ID_W    binary index of the winner
module rr_picker
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter bit          RR_MODE = MODE_RR
) (
    input  logic [NUM_CH-1:0]         eligible,
    input  logic [$clog2(NUM_CH)-1:0] last_grant,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_idx
);

    localparam int unsigned ID_W = $clog2(NUM_CH);

    logic [ID_W-1:0] cand;
    logic            found;

    // Walk the channels in priority order; the first eligible one wins.
    // Round-robin order starts just after last_grant and wraps.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (RR_MODE == MODE_RR) begin
                cand = ID_W'((32'(last_grant) + 32'd1 + i) % NUM_CH);
            end else begin
                cand = ID_W'(i);
            end
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ddr_channel_arb_n.sv
// N-channel arbiter in front of a single-ported DDR controller.
// One operation is outstanding at a time: a granted request is latched,
// issued as a one-cycle chip-enable pulse, and its completion is routed
// back to the owning channel unless that channel flushed it meanwhile.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready       per-channel handshake (ready is one-hot)
//   req_index/write/burst     packed request fields, channel 0 in LSBs
//   req_wmask/req_wdata       packed write mask/data
//   req_flush                 drop this channel's pending/in-flight response
//   resp_done                 one-cycle completion pulse to the owner
//   resp_rdata/burst_data     last captured read data
//   busy, grant_id            arbiter occupied, current owner
//   ddr_*                     DDR controller command/response interface
module ddr_channel_arb_n
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned INDEX_W = 19,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned BURST_W = 512,
    parameter bit          RR_MODE = MODE_RR
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           req_valid,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic [NUM_CH*INDEX_W-1:0]   req_index,
    input  logic [NUM_CH-1:0]           req_write,
    input  logic [NUM_CH-1:0]           req_burst,
    input  logic [NUM_CH*DATA_W-1:0]    req_wmask,
    input  logic [NUM_CH*DATA_W-1:0]    req_wdata,
    input  logic [NUM_CH-1:0]           req_flush,
    output logic [NUM_CH-1:0]           resp_done,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic [BURST_W-1:0]          resp_burst_data,
    output logic                        busy,
    output logic [$clog2(NUM_CH)-1:0]   grant_id,
    output logic                        ddr_chip_enable,
    output logic [INDEX_W-1:0]          ddr_index,
    output logic                        ddr_write_enable,
    output logic                        ddr_burst_mode,
    output logic [DATA_W-1:0]           ddr_write_mask,
    output logic [DATA_W-1:0]           ddr_write_data,
    input  logic [DATA_W-1:0]           ddr_read_data,
    input  logic [BURST_W-1:0]          ddr_burst_read_data,
    input  logic                        ddr_operation_done,
    input  logic                        ddr_ready
);

    localparam int unsigned ID_W = $clog2(NUM_CH);

    arb_state_t          state;
    logic [ID_W-1:0]     last_grant;
    logic                kill;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   pick;
    logic [ID_W-1:0]     pick_idx;
    logic                handshake;
    logic [NUM_CH-1:0]   owner_oh;
    logic                owner_flush;
    logic                kill_next;

    logic [INDEX_W-1:0]  sel_index;
    logic                sel_write;
    logic                sel_burst;
    logic [DATA_W-1:0]   sel_wmask;
    logic [DATA_W-1:0]   sel_wdata;

    assign eligible = req_valid & ~req_flush;

    rr_picker #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_picker (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_idx  (pick_idx)
    );

    assign req_ready = (state == IDLE && ddr_ready) ? pick : '0;
    assign handshake = |req_ready;
    assign busy      = (state != IDLE);

    // Only the owner's flush matters once an operation is in flight; the
    // flag is sampled together with done so a same-cycle flush still kills.
    assign owner_oh    = NUM_CH'(1) << grant_id;
    assign owner_flush = |(req_flush & owner_oh);
    assign kill_next   = kill | (((state == ISSUE) || (state == WAIT)) && owner_flush);

    always_comb begin
        sel_index = '0;
        sel_write = 1'b0;
        sel_burst = 1'b0;
        sel_wmask = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pick[i]) begin
                sel_index = req_index[i*INDEX_W +: INDEX_W];
                sel_write = req_write[i];
                sel_burst = req_burst[i];
                sel_wmask = req_wmask[i*DATA_W +: DATA_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            last_grant       <= ID_W'(NUM_CH - 1);
            kill             <= 1'b0;
            grant_id         <= '0;
            ddr_chip_enable  <= 1'b0;
            ddr_index        <= '0;
            ddr_write_enable <= 1'b0;
            ddr_burst_mode   <= 1'b0;
            ddr_write_mask   <= '0;
            ddr_write_data   <= '0;
            resp_done        <= '0;
            resp_rdata       <= '0;
            resp_burst_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state            <= ISSUE;
                        grant_id         <= pick_idx;
                        last_grant       <= pick_idx;
                        kill             <= 1'b0;
                        ddr_chip_enable  <= 1'b1;
                        ddr_index        <= sel_index;
                        ddr_write_enable <= sel_write;
                        // Burst applies to reads only.
                        ddr_burst_mode   <= sel_burst & ~sel_write;
                        ddr_write_mask   <= sel_wmask;
                        ddr_write_data   <= sel_wdata;
                    end
                end
                ISSUE: begin
                    ddr_chip_enable <= 1'b0;
                    kill            <= kill_next;
                    state           <= WAIT;
                end
                WAIT: begin
                    kill <= kill_next;
                    if (ddr_operation_done) begin
                        resp_rdata      <= ddr_read_data;
                        resp_burst_data <= ddr_burst_read_data;
                        resp_done       <= kill_next ? '0 : owner_oh;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    resp_done <= '0;
                    kill      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_channel_arb_n.sv
module tb_ddr_channel_arb_n;

    localparam int NUM_CH  = 3;
    localparam int INDEX_W = 19;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 512;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // shared request payload
    logic [NUM_CH*INDEX_W-1:0] req_index;
    logic [NUM_CH-1:0]         req_write, req_burst;
    logic [NUM_CH*DATA_W-1:0]  req_wmask, req_wdata;

    // DUT A (round-robin)
    logic [NUM_CH-1:0]  req_valid, req_ready, req_flush, resp_done;
    logic [DATA_W-1:0]  resp_rdata;
    logic [BURST_W-1:0] resp_burst_data;
    logic               busy;
    logic [1:0]         grant_id;
    logic               ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
    logic [INDEX_W-1:0] ddr_index;
    logic [DATA_W-1:0]  ddr_write_mask, ddr_write_data, ddr_read_data;
    logic [BURST_W-1:0] ddr_burst_read_data;
    logic               ddr_done_a, done_inj, done_a, ddr_ready;
    assign done_a = ddr_done_a | done_inj;

    // DUT B (fixed priority)
    logic [NUM_CH-1:0]  b_req_valid, b_req_ready, b_req_flush, b_resp_done;
    logic [DATA_W-1:0]  b_resp_rdata, b_rdata;
    logic [BURST_W-1:0] b_resp_burst_data, b_bdata;
    logic               b_busy, b_ce, b_we, b_bm, b_done, b_ddr_ready;
    logic [1:0]         b_grant_id;
    logic [INDEX_W-1:0] b_ddr_index;
    logic [DATA_W-1:0]  b_wmask, b_wdata;

    ddr_channel_arb_n #(.NUM_CH(NUM_CH), .INDEX_W(INDEX_W), .DATA_W(DATA_W),
                        .BURST_W(BURST_W), .RR_MODE(1'b1)) dut_rr (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_write(req_write), .req_burst(req_burst), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .req_flush(req_flush), .resp_done(resp_done),
        .resp_rdata(resp_rdata), .resp_burst_data(resp_burst_data), .busy(busy),
        .grant_id(grant_id), .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
        .ddr_read_data(ddr_read_data), .ddr_burst_read_data(ddr_burst_read_data),
        .ddr_operation_done(done_a), .ddr_ready(ddr_ready)
    );

    ddr_channel_arb_n #(.NUM_CH(NUM_CH), .INDEX_W(INDEX_W), .DATA_W(DATA_W),
                        .BURST_W(BURST_W), .RR_MODE(1'b0)) dut_fixed (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_index(req_index),
        .req_write(req_write), .req_burst(req_burst), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .req_flush(b_req_flush), .resp_done(b_resp_done),
        .resp_rdata(b_resp_rdata), .resp_burst_data(b_resp_burst_data), .busy(b_busy),
        .grant_id(b_grant_id), .ddr_chip_enable(b_ce), .ddr_index(b_ddr_index),
        .ddr_write_enable(b_we), .ddr_burst_mode(b_bm),
        .ddr_write_mask(b_wmask), .ddr_write_data(b_wdata),
        .ddr_read_data(b_rdata), .ddr_burst_read_data(b_bdata),
        .ddr_operation_done(b_done), .ddr_ready(b_ddr_ready)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // DDR model data, derived from the index the DUT presented
    function automatic logic [DATA_W-1:0] rd_of(input logic [INDEX_W-1:0] idx);
        return 64'hDEAD ^ ({45'h0, idx ^ 19'h100} << 16);
    endfunction

    function automatic logic [BURST_W-1:0] bd_of(input logic [INDEX_W-1:0] idx);
        return ({448'h0, rd_of(idx)} << 8) | 512'hAB;
    endfunction

    function automatic int oh2i(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int                 ch;
        logic [DATA_W-1:0]  rd;
        logic [BURST_W-1:0] bd;
        bit                 killed;
    } exp_t;

    exp_t sb[$];
    int   grants_a[$];
    int   q_b[$];
    int   grants_b[$];
    int   n_resp_a = 0;
    int   n_resp_b = 0;
    bit   ddr_auto = 1'b1;
    int   ddr_lat  = 3;

    // DDR responder for DUT A: done arrives ddr_lat cycles after chip enable
    initial begin
        logic [INDEX_W-1:0] cap;
        ddr_done_a = 1'b0;
        ddr_read_data = '0;
        ddr_burst_read_data = '0;
        forever begin
            @(negedge clock);
            if (ddr_auto && ddr_chip_enable === 1'b1) begin
                cap = ddr_index;
                repeat (ddr_lat) @(posedge clock);
                #1;
                ddr_done_a = 1'b1;
                ddr_read_data = rd_of(cap);
                ddr_burst_read_data = bd_of(cap);
                @(posedge clock);
                #1 ddr_done_a = 1'b0;
            end
        end
    end

    // DDR responder for DUT B: fixed latency of 2
    initial begin
        b_done = 1'b0;
        forever begin
            @(negedge clock);
            if (b_ce === 1'b1) begin
                repeat (2) @(posedge clock);
                #1 b_done = 1'b1;
                @(posedge clock);
                #1 b_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor for DUT A
    initial begin
        bit   resp_due = 1'b0;
        exp_t e;
        int   ch;
        forever begin
            @(negedge clock);
            if (resp_due) begin
                if (sb.size() == 0) begin
                    check_val("late_resp", resp_done, '0);
                end else begin
                    e = sb.pop_front();
                    if (e.killed) begin
                        check_val("kill_resp", resp_done, '0);
                    end else begin
                        check_val("resp_done", resp_done, 3'b1 << e.ch);
                        check_val("resp_rdata", resp_rdata, e.rd);
                        check_val("resp_burst", resp_burst_data, e.bd);
                        n_resp_a++;
                    end
                end
            end else if (resp_done != '0) begin
                check_val("spurious_resp", resp_done, '0);
            end
            resp_due = done_a;
            if ((req_valid & req_ready) != '0) begin
                ch = oh2i(req_valid & req_ready);
                e.ch = ch;
                e.rd = rd_of(req_index[ch*INDEX_W +: INDEX_W]);
                e.bd = bd_of(req_index[ch*INDEX_W +: INDEX_W]);
                e.killed = 1'b0;
                sb.push_back(e);
                grants_a.push_back(ch);
            end
        end
    end

    // Monitor for DUT B
    initial begin
        int ch;
        forever begin
            @(negedge clock);
            if (b_resp_done != '0) begin
                if (q_b.size() == 0) begin
                    check_val("b_spurious", b_resp_done, '0);
                end else begin
                    ch = q_b.pop_front();
                    check_val("b_resp", b_resp_done, 3'b1 << ch);
                    n_resp_b++;
                end
            end
            if ((b_req_valid & b_req_ready) != '0) begin
                ch = oh2i(b_req_valid & b_req_ready);
                q_b.push_back(ch);
                grants_b.push_back(ch);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int ch, input logic [INDEX_W-1:0] idx);
        req_index[ch*INDEX_W +: INDEX_W] = idx;
    endtask

    task automatic wait_hs(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if ((req_valid & req_ready) != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val(tag, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clock);
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_val(tag, busy, 0);
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_ready"}, req_ready, '0);
        check_val({pfx, "_resp_done"}, resp_done, '0);
        check_val({pfx, "_busy"}, busy, 0);
        check_val({pfx, "_grant_id"}, grant_id, 0);
        check_val({pfx, "_ce"}, ddr_chip_enable, 0);
        check_val({pfx, "_index"}, ddr_index, 0);
        check_val({pfx, "_we"}, ddr_write_enable, 0);
        check_val({pfx, "_bm"}, ddr_burst_mode, 0);
        check_val({pfx, "_wmask"}, ddr_write_mask, 0);
        check_val({pfx, "_wdata"}, ddr_write_data, 0);
        check_val({pfx, "_rdata"}, resp_rdata, 0);
        check_val({pfx, "_bdata"}, resp_burst_data, 0);
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        req_index = '0; req_write = '0; req_burst = '0;
        req_wmask = '0; req_wdata = '0;
        req_valid = '0; req_flush = '0; ddr_ready = 1'b1; done_inj = 1'b0;
        b_req_valid = '0; b_req_flush = '0; b_ddr_ready = 1'b1;
        b_rdata = '0; b_bdata = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("rst");
        check_val("b_rst_busy", b_busy, 0);
        @(posedge clock); #1 reset_n = 1'b1;

        // ddr_ready low: no grant even with everyone requesting
        set_ch(0, 19'h11); set_ch(1, 19'h22); set_ch(2, 19'h33);
        @(posedge clock); #1;
        req_valid = '1; ddr_ready = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_val("ready_low", req_ready, '0);
        end
        check_val("ready_low_busy", busy, 0);

        // round-robin with all channels valid
        @(posedge clock); #1;
        grants_a.delete();
        base = n_resp_a;
        ddr_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock); #1;
            if (grants_a.size() >= 4) req_valid = '0;
            if (grants_a.size() >= 4 && !busy) break;
        end
        req_valid = '0;
        check_val("rr_count", grants_a.size(), 4);
        if (grants_a.size() >= 4) begin
            check_val("rr_g0", grants_a[0], 0);
            check_val("rr_g1", grants_a[1], 1);
            check_val("rr_g2", grants_a[2], 2);
            check_val("rr_g3", grants_a[3], 0);
        end
        check_val("rr_resps", n_resp_a - base, 4);
        check_val("rr_sb_empty", sb.size(), 0);

        // ch1 read at 0x100, done 3 cycles after chip enable, non-owner flush
        set_ch(1, 19'h100);
        ddr_lat = 3;
        @(posedge clock); #1 req_valid = 3'b010;
        wait_hs("t1_hs_timeout");
        check_val("t1_ready", req_ready, 3'b010);
        @(posedge clock); #1 req_valid = '0;
        @(negedge clock);
        check_val("t1_ce", ddr_chip_enable, 1);
        check_val("t1_index", ddr_index, 19'h100);
        check_val("t1_grant_id", grant_id, 1);
        check_val("t1_we", ddr_write_enable, 0);
        @(posedge clock); #1 req_flush = 3'b001;
        @(posedge clock); #1 req_flush = '0;
        repeat (2) @(negedge clock);
        check_val("t1_ce_low", ddr_chip_enable, 0);
        @(negedge clock);
        check_val("t1_resp_c5", resp_done, 3'b010);
        check_val("t1_rdata_c5", resp_rdata, 64'hDEAD);
        wait_idle("t1_idle");

        // ch2 burst read flushed while waiting
        set_ch(2, 19'h2AB);
        req_burst = 3'b100;
        @(posedge clock); #1 req_valid = 3'b100;
        wait_hs("t4_hs_timeout");
        @(posedge clock); #1 req_valid = '0;
        @(negedge clock);
        check_val("t4_ce", ddr_chip_enable, 1);
        check_val("t4_bm", ddr_burst_mode, 1);
        @(posedge clock); #1;
        req_flush = 3'b100;
        if (sb.size() > 0) sb[0].killed = 1'b1;
        @(posedge clock); #1 req_flush = '0;
        wait_idle("t4_idle");
        check_val("t4_sb_empty", sb.size(), 0);
        req_burst = '0;

        // ch0 write with burst requested: burst mode suppressed, fields held
        set_ch(0, 19'h55);
        req_write = 3'b001; req_burst = 3'b001;
        req_wmask[DATA_W-1:0] = 64'hFF;
        req_wdata[DATA_W-1:0] = 64'h1234;
        ddr_lat = 4;
        @(posedge clock); #1 req_valid = 3'b001;
        wait_hs("t5_hs_timeout");
        @(posedge clock); #1;
        req_valid = '0; req_write = '0; req_burst = '0; req_wmask = '1; req_wdata = '1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (n == 0) check_val("t5_ce", ddr_chip_enable, 1);
            check_val("t5_we", ddr_write_enable, 1);
            check_val("t5_bm", ddr_burst_mode, 0);
            check_val("t5_wmask", ddr_write_mask, 64'hFF);
            check_val("t5_wdata", ddr_write_data, 64'h1234);
            if (done_a) break;
        end
        wait_idle("t5_idle");
        req_wmask = '0; req_wdata = '0;
        ddr_lat = 3;

        // reset during WAIT, late done afterwards, channel 0 first again
        ddr_auto = 1'b0;
        set_ch(1, 19'h77);
        @(posedge clock); #1 req_valid = 3'b010;
        wait_hs("t6_hs_timeout");
        @(posedge clock); #1 req_valid = '0;
        @(posedge clock); #1;
        check_val("t6_in_wait", busy, 1);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clock);
        check_reset_state("t6");
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1 done_inj = 1'b1;
        @(posedge clock); #1 done_inj = 1'b0;
        @(negedge clock);
        check_val("t6_late_busy", busy, 0);
        ddr_auto = 1'b1;
        @(posedge clock); #1 req_valid = '1;
        @(negedge clock);
        check_val("t6_first_grant", req_ready, 3'b001);
        @(posedge clock); #1 req_valid = '0;
        wait_idle("t6_idle");
        check_val("t6_sb_empty", sb.size(), 0);

        // fixed priority on DUT B
        grants_b.delete();
        @(posedge clock); #1 b_req_valid = '1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clock); #1;
            if (grants_b.size() >= 5) b_req_valid = '0;
            else if (grants_b.size() >= 4) b_req_valid = 3'b100;
            else if (grants_b.size() >= 3) b_req_valid = 3'b110;
            if (grants_b.size() >= 5 && !b_busy) break;
        end
        b_req_valid = '0;
        check_val("fx_count", grants_b.size(), 5);
        if (grants_b.size() >= 5) begin
            check_val("fx_g0", grants_b[0], 0);
            check_val("fx_g1", grants_b[1], 0);
            check_val("fx_g2", grants_b[2], 0);
            check_val("fx_g3", grants_b[3], 1);
            check_val("fx_g4", grants_b[4], 2);
        end
        check_val("fx_resps", n_resp_b, 5);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
